// File: rtl/bridge_stream_port.sv
// Register-bridge leaf that feeds a TX stream FIFO to the core and drains an RX stream FIFO
// from the core, with sticky overflow/underflow flags and a flush/clear control register.
module bridge_stream_port #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      bridge_addr,
    input  logic [WIDTH-1:0] bridge_wr_data,
    input  logic             bridge_wr,
    input  logic             bridge_rd,
    output logic [WIDTH-1:0] bridge_rd_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0]    ADDR_TXDATA  = 2'd0;
    localparam logic [1:0]    ADDR_RXDATA  = 2'd1;
    localparam logic [1:0]    ADDR_STATUS  = 2'd2;
    localparam logic [1:0]    ADDR_CONTROL = 2'd3;
    localparam logic [AW-1:0] PTR_ZERO     = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE      = AW'(1);
    localparam logic [CW-1:0] CNT_ZERO     = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE      = CW'(1);
    localparam logic [CW-1:0] CNT_FULL     = CW'(DEPTH);

    logic [WIDTH-1:0] tx_mem_r [DEPTH];
    logic [WIDTH-1:0] rx_mem_r [DEPTH];
    logic [AW-1:0]    tx_wr_ptr_r, tx_rd_ptr_r, rx_wr_ptr_r, rx_rd_ptr_r;
    logic [CW-1:0]    tx_count_r, rx_count_r;
    logic [CW-1:0]    tx_count_nxt_s, rx_count_nxt_s;
    logic             tx_overflow_r, rx_underflow_r;
    logic [WIDTH-1:0] rd_data_r, rd_data_nxt_s;
    logic [WIDTH-1:0] status_s;

    logic [1:0] reg_sel_s;
    logic       wr_txdata_s, wr_control_s, rd_rxdata_s;
    logic       tx_full_s, tx_empty_s, rx_full_s, rx_empty_s;
    logic       tx_push_s, tx_pop_s, rx_push_s, rx_pop_s;
    logic       tx_flush_s, rx_flush_s, clr_flags_s;
    logic       tx_ovf_set_s, rx_udf_set_s;
    logic       unused_addr_s;

    assign reg_sel_s     = bridge_addr[3:2];
    assign unused_addr_s = ^{bridge_addr[31:4], bridge_addr[1:0]};

    assign wr_txdata_s  = bridge_wr && (reg_sel_s == ADDR_TXDATA);
    assign wr_control_s = bridge_wr && (reg_sel_s == ADDR_CONTROL);
    assign rd_rxdata_s  = bridge_rd && (reg_sel_s == ADDR_RXDATA);

    assign tx_full_s  = (tx_count_r == CNT_FULL);
    assign tx_empty_s = (tx_count_r == CNT_ZERO);
    assign rx_full_s  = (rx_count_r == CNT_FULL);
    assign rx_empty_s = (rx_count_r == CNT_ZERO);

    assign tx_flush_s  = wr_control_s && bridge_wr_data[0];
    assign rx_flush_s  = wr_control_s && bridge_wr_data[1];
    assign clr_flags_s = wr_control_s && bridge_wr_data[2];

    // A full TX FIFO still accepts a write when the core pops in the same cycle.
    assign tx_pop_s     = !tx_empty_s && out_ready;
    assign tx_push_s    = wr_txdata_s && (!tx_full_s || tx_pop_s);
    assign tx_ovf_set_s = wr_txdata_s && tx_full_s && !tx_pop_s;
    assign rx_push_s    = in_valid && !rx_full_s;
    assign rx_pop_s     = rd_rxdata_s && !rx_empty_s;
    assign rx_udf_set_s = rd_rxdata_s && rx_empty_s;

    assign out_valid      = !tx_empty_s;
    assign out_data       = tx_empty_s ? {WIDTH{1'b0}} : tx_mem_r[tx_rd_ptr_r];
    assign in_ready       = !rx_full_s;
    assign bridge_rd_data = rd_data_r;

    assign status_s = {tx_overflow_r, rx_underflow_r, 14'd0, 8'(tx_count_r), 8'(rx_count_r)};

    // Next occupancy of both FIFOs; a flush overrides any same-cycle push or pop.
    always_comb begin
        tx_count_nxt_s = tx_count_r;
        rx_count_nxt_s = rx_count_r;
        if (tx_flush_s) begin
            tx_count_nxt_s = CNT_ZERO;
        end else if (tx_push_s && !tx_pop_s) begin
            tx_count_nxt_s = tx_count_r + CNT_ONE;
        end else if (!tx_push_s && tx_pop_s) begin
            tx_count_nxt_s = tx_count_r - CNT_ONE;
        end else begin
            tx_count_nxt_s = tx_count_r;
        end
        if (rx_flush_s) begin
            rx_count_nxt_s = CNT_ZERO;
        end else if (rx_push_s && !rx_pop_s) begin
            rx_count_nxt_s = rx_count_r + CNT_ONE;
        end else if (!rx_push_s && rx_pop_s) begin
            rx_count_nxt_s = rx_count_r - CNT_ONE;
        end else begin
            rx_count_nxt_s = rx_count_r;
        end
    end

    // Read-data mux; the value holds between reads so a late sampler still sees it.
    always_comb begin
        rd_data_nxt_s = rd_data_r;
        if (bridge_rd) begin
            case (reg_sel_s)
                ADDR_RXDATA: rd_data_nxt_s = rx_empty_s ? {WIDTH{1'b0}} : rx_mem_r[rx_rd_ptr_r];
                ADDR_STATUS: rd_data_nxt_s = status_s;
                default:     rd_data_nxt_s = {WIDTH{1'b0}};
            endcase
        end else begin
            rd_data_nxt_s = rd_data_r;
        end
    end

    // FIFO storage; contents need no reset because emptiness is tracked by the counts.
    always_ff @(posedge clk) begin
        if (tx_push_s && !tx_flush_s) begin
            tx_mem_r[tx_wr_ptr_r] <= bridge_wr_data;
        end
        if (rx_push_s && !rx_flush_s) begin
            rx_mem_r[rx_wr_ptr_r] <= in_data;
        end
    end

    // Pointers, counts, sticky flags and read-data register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr_ptr_r    <= PTR_ZERO;
            tx_rd_ptr_r    <= PTR_ZERO;
            rx_wr_ptr_r    <= PTR_ZERO;
            rx_rd_ptr_r    <= PTR_ZERO;
            tx_count_r     <= CNT_ZERO;
            rx_count_r     <= CNT_ZERO;
            tx_overflow_r  <= 1'b0;
            rx_underflow_r <= 1'b0;
            rd_data_r      <= {WIDTH{1'b0}};
        end else begin
            tx_count_r <= tx_count_nxt_s;
            rx_count_r <= rx_count_nxt_s;
            rd_data_r  <= rd_data_nxt_s;
            if (tx_flush_s) begin
                tx_wr_ptr_r <= PTR_ZERO;
                tx_rd_ptr_r <= PTR_ZERO;
            end else begin
                if (tx_push_s) tx_wr_ptr_r <= tx_wr_ptr_r + PTR_ONE;
                if (tx_pop_s)  tx_rd_ptr_r <= tx_rd_ptr_r + PTR_ONE;
            end
            if (rx_flush_s) begin
                rx_wr_ptr_r <= PTR_ZERO;
                rx_rd_ptr_r <= PTR_ZERO;
            end else begin
                if (rx_push_s) rx_wr_ptr_r <= rx_wr_ptr_r + PTR_ONE;
                if (rx_pop_s)  rx_rd_ptr_r <= rx_rd_ptr_r + PTR_ONE;
            end
            // A new error event in the same cycle as a clear is kept.
            tx_overflow_r  <= tx_ovf_set_s || (tx_overflow_r && !clr_flags_s);
            rx_underflow_r <= rx_udf_set_s || (rx_underflow_r && !clr_flags_s);
        end
    end

endmodule

// File: tb/tb_bridge_stream_port.sv
// Directed self-checking bench for bridge_stream_port (DEPTH=16, WIDTH=32).
module tb_bridge_stream_port;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bridge_addr;
    logic [31:0] bridge_wr_data;
    logic        bridge_wr;
    logic        bridge_rd;
    logic [31:0] bridge_rd_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;

    int errors = 0;
    int checks = 0;

    bridge_stream_port #(.DEPTH(16), .WIDTH(32)) dut (
        .clk(clk), .reset(reset),
        .bridge_addr(bridge_addr), .bridge_wr_data(bridge_wr_data),
        .bridge_wr(bridge_wr), .bridge_rd(bridge_rd), .bridge_rd_data(bridge_rd_data),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [1:0] reg_sel, input logic [31:0] data);
        bridge_addr    = {28'd0, reg_sel, 2'b00};
        bridge_wr_data = data;
        bridge_wr      = 1'b1;
        tick();
        bridge_wr      = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] reg_sel);
        bridge_addr = {28'd0, reg_sel, 2'b00};
        bridge_rd   = 1'b1;
        tick();
        bridge_rd   = 1'b0;
    endtask

    task automatic test_reset();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        checks++; if (bridge_rd_data !== 32'h0) begin errors++; $display("FAIL rst_rd_data: got %h want 0", bridge_rd_data); end
    endtask

    task automatic test_tx_basic();
        out_ready = 1'b0;
        bus_write(2'd0, 32'hA5A5_0001);
        bus_write(2'd0, 32'hA5A5_0002);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL tx_valid: got %b want 1", out_valid); end
        checks++; if (out_data !== 32'hA5A5_0001) begin errors++; $display("FAIL tx_head0: got %h want a5a50001", out_data); end
        bus_read(2'd2);
        checks++; if (bridge_rd_data !== 32'h0000_0200) begin errors++; $display("FAIL tx_status2: got %h want 00000200", bridge_rd_data); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_data !== 32'hA5A5_0002) begin errors++; $display("FAIL tx_head1: got %h want a5a50002", out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL tx_drained: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_tx_overflow();
        for (int i = 0; i < 17; i++) bus_write(2'd0, 32'h0000_0100 + 32'(i));
        bus_read(2'd2);
        checks++; if (bridge_rd_data !== 32'h8000_1000) begin errors++; $display("FAIL ovf_status: got %h want 80001000", bridge_rd_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (out_data !== 32'h0000_0100 + 32'(i)) begin
                errors++; $display("FAIL ovf_drain%0d: got %h want %h", i, out_data, 32'h0000_0100 + 32'(i));
            end
            tick();
        end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_17th_dropped: got %b want 0", out_valid); end
        out_ready = 1'b0;
        bus_write(2'd3, 32'h0000_0004);
        bus_read(2'd2);
        checks++; if (bridge_rd_data !== 32'h0) begin errors++; $display("FAIL ovf_cleared: got %h want 0", bridge_rd_data); end
    endtask

    task automatic test_rx_read();
        in_data = 32'h1234_5678; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        bus_read(2'd1);
        checks++; if (bridge_rd_data !== 32'h1234_5678) begin errors++; $display("FAIL rx_read: got %h want 12345678", bridge_rd_data); end
        bus_write(2'd2, 32'hFFFF_FFFF);
        tick(); tick();
        checks++; if (bridge_rd_data !== 32'h1234_5678) begin errors++; $display("FAIL rx_hold: got %h want 12345678", bridge_rd_data); end
        bus_read(2'd1);
        checks++; if (bridge_rd_data !== 32'h0) begin errors++; $display("FAIL rx_underflow_data: got %h want 0", bridge_rd_data); end
        bus_read(2'd2);
        checks++; if (bridge_rd_data !== 32'h4000_0000) begin errors++; $display("FAIL rx_underflow_status: got %h want 40000000", bridge_rd_data); end
        bus_write(2'd3, 32'h0000_0004);
    endtask

    task automatic test_rx_full_flush();
        in_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_data = 32'h0000_0200 + 32'(i);
            tick();
        end
        in_data = 32'h0000_02FF;
        tick();
        in_valid = 1'b0;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rx_full_ready: got %b want 0", in_ready); end
        bus_read(2'd2);
        checks++; if (bridge_rd_data !== 32'h0000_0010) begin errors++; $display("FAIL rx_full_status: got %h want 00000010", bridge_rd_data); end
        bus_read(2'd1);
        checks++; if (bridge_rd_data !== 32'h0000_0200) begin errors++; $display("FAIL rx_full_head: got %h want 00000200", bridge_rd_data); end
        bus_write(2'd3, 32'h0000_0006);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rx_flush_ready: got %b want 1", in_ready); end
        bus_read(2'd2);
        checks++; if (bridge_rd_data !== 32'h0) begin errors++; $display("FAIL rx_flush_status: got %h want 0", bridge_rd_data); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) bus_write(2'd0, 32'h0000_0300 + 32'(i));
        bridge_addr = 32'h0; bridge_wr_data = 32'h0000_03FF; bridge_wr = 1'b1; out_ready = 1'b1;
        tick();
        bridge_wr = 1'b0; out_ready = 1'b0;
        bus_read(2'd2);
        checks++; if (bridge_rd_data !== 32'h0000_1000) begin errors++; $display("FAIL b2b_status: got %h want 00001000", bridge_rd_data); end
        out_ready = 1'b1;
        for (int i = 1; i < 16; i++) begin
            checks++;
            if (out_data !== 32'h0000_0300 + 32'(i)) begin
                errors++; $display("FAIL b2b_drain%0d: got %h want %h", i, out_data, 32'h0000_0300 + 32'(i));
            end
            tick();
        end
        checks++; if (out_data !== 32'h0000_03FF) begin errors++; $display("FAIL b2b_last: got %h want 000003ff", out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_empty: got %b want 0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_rx_empty_push_read();
        in_data = 32'h0000_CAFE; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        bus_read(2'd1);
        checks++; if (bridge_rd_data !== 32'h0000_CAFE) begin errors++; $display("FAIL rxe_first: got %h want 0000cafe", bridge_rd_data); end
        in_data = 32'h0000_BEEF; in_valid = 1'b1;
        bridge_addr = 32'h4; bridge_rd = 1'b1;
        tick();
        in_valid = 1'b0; bridge_rd = 1'b0;
        checks++; if (bridge_rd_data !== 32'h0) begin errors++; $display("FAIL rxe_simul_data: got %h want 0", bridge_rd_data); end
        bus_read(2'd2);
        checks++; if (bridge_rd_data !== 32'h4000_0001) begin errors++; $display("FAIL rxe_status: got %h want 40000001", bridge_rd_data); end
        bridge_addr = 32'hC; bridge_wr_data = 32'h0000_0004; bridge_wr = 1'b1; bridge_rd = 1'b1;
        tick();
        bridge_wr = 1'b0; bridge_rd = 1'b0;
        checks++; if (bridge_rd_data !== 32'h0) begin errors++; $display("FAIL rdwr_ctrl_read: got %h want 0", bridge_rd_data); end
        bus_read(2'd2);
        checks++; if (bridge_rd_data !== 32'h0000_0001) begin errors++; $display("FAIL rdwr_status: got %h want 00000001", bridge_rd_data); end
        bus_read(2'd1);
        checks++; if (bridge_rd_data !== 32'h0000_BEEF) begin errors++; $display("FAIL rxe_retained: got %h want 0000beef", bridge_rd_data); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) bus_write(2'd0, 32'h0000_0400 + 32'(i));
        in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_data = 32'h0000_0500 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        bus_read(2'd2);
        checks++; if (bridge_rd_data !== 32'h0000_0808) begin errors++; $display("FAIL mid_status: got %h want 00000808", bridge_rd_data); end
        #2 reset = 1'b1;
        #1;
        test_reset();
        tick();
        reset = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_post_valid: got %b want 0", out_valid); end
        bus_read(2'd2);
        checks++; if (bridge_rd_data !== 32'h0) begin errors++; $display("FAIL mid_post_status: got %h want 0", bridge_rd_data); end
    endtask

    initial begin
        reset = 1'b0; bridge_addr = 32'h0; bridge_wr_data = 32'h0;
        bridge_wr = 1'b0; bridge_rd = 1'b0; out_ready = 1'b0;
        in_data = 32'h0; in_valid = 1'b0;
        #1 reset = 1'b1;
        #2;
        test_reset();
        tick(); tick();
        reset = 1'b0;
        tick();
        test_tx_basic();
        test_tx_overflow();
        test_rx_read();
        test_rx_full_flush();
        test_back_to_back();
        test_rx_empty_push_read();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
